// File: rtl/alu_seq_if.sv
// Execute-stage ALU handshake bundle: operand/op request and registered result/flags.
// The master side issues operations; alu_seq is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       control;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             Zero;
    logic             LessThan;
    logic             div_by_zero;

    modport master (
        output in_valid, A, B, control,
        input  in_ready, out_valid, out, Zero, LessThan, div_by_zero
    );

    modport slave (
        input  in_valid, A, B, control,
        output in_ready, out_valid, out, Zero, LessThan, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIVU/REMU.
// Define ALU_SEQ_SIGNED_DIV_EN to add signed DIV/REM (magnitude divide with sign fix-up).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
`ifdef ALU_SEQ_SIGNED_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_REM  = 4'b1100;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] wrk_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             zero_q;
    logic             lt_q;
    logic             dbz_q;

    logic             is_multi_d;
    logic [WIDTH-1:0] single_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] dvs_d;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   rem_sh_d;
    logic             rem_ge_d;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;
    logic             dbz_d;
    logic [WIDTH-1:0] final_d;

    always_comb begin
        is_multi_d = 1'b0;
        case (bus.control)
            OP_MUL, OP_DIVU, OP_REMU: is_multi_d = 1'b1;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            OP_DIV, OP_REM:           is_multi_d = 1'b1;
`endif
            default:                  is_multi_d = 1'b0;
        endcase
    end

    always_comb begin
        single_d = bus.A + bus.B;
        case (bus.control)
            OP_SUB:  single_d = bus.A - bus.B;
            OP_AND:  single_d = bus.A & bus.B;
            OP_OR:   single_d = bus.A | bus.B;
            OP_SLTU: single_d = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            OP_SLT:  single_d = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            OP_XOR:  single_d = bus.A ^ bus.B;
            default: single_d = bus.A + bus.B;
        endcase
    end

    // Signed divides run on magnitudes; the sign is restored when the result is registered.
    always_comb begin
        dvd_d = bus.A;
        dvs_d = bus.B;
`ifdef ALU_SEQ_SIGNED_DIV_EN
        if (bus.control == OP_DIV || bus.control == OP_REM) begin
            if (bus.A[WIDTH-1]) dvd_d = -bus.A;
            if (bus.B[WIDTH-1]) dvs_d = -bus.B;
        end
`endif
    end

    always_comb begin
        mul_acc_d = acc_q + (wrk_q[0] ? opnd_q : '0);
        rem_sh_d  = {acc_q, wrk_q[WIDTH-1]};
        rem_ge_d  = rem_sh_d >= {1'b0, opnd_q};
        div_rem_d = rem_ge_d ? WIDTH'(rem_sh_d - {1'b0, opnd_q}) : rem_sh_d[WIDTH-1:0];
        div_quo_d = {wrk_q[WIDTH-2:0], rem_ge_d};
        dbz_d     = (b_q == '0) && (op_q != OP_MUL);
        case (op_q)
            OP_DIVU: final_d = dbz_d ? '1 : div_quo_d;
            OP_REMU: final_d = dbz_d ? a_q : div_rem_d;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            OP_DIV:  final_d = dbz_d ? '1
                             : ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo_d : div_quo_d);
            OP_REM:  final_d = dbz_d ? a_q
                             : (a_q[WIDTH-1] ? -div_rem_d : div_rem_d);
`endif
            default: final_d = mul_acc_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            wrk_q       <= '0;
            opnd_q      <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.A;
                        b_q        <= bus.B;
                        op_q       <= bus.control;
                        in_ready_q <= 1'b0;
                        if (is_multi_d) begin
                            state_q <= S_RUN;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            // MUL: wrk = multiplier (shifts right), opnd = multiplicand (shifts left).
                            // Divides: wrk = dividend/quotient (shifts left), opnd = divisor.
                            wrk_q   <= (bus.control == OP_MUL) ? bus.B : dvd_d;
                            opnd_q  <= (bus.control == OP_MUL) ? bus.A : dvs_d;
                        end else begin
                            state_q     <= S_DONE;
                            out_q       <= single_d;
                            zero_q      <= (bus.A == bus.B);
                            lt_q        <= ($signed(bus.A) < $signed(bus.B));
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q == OP_MUL) begin
                        acc_q  <= mul_acc_d;
                        wrk_q  <= wrk_q >> 1;
                        opnd_q <= opnd_q << 1;
                    end else if (!dbz_d) begin
                        acc_q <= div_rem_d;
                        wrk_q <= div_quo_d;
                    end
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_q     <= S_DONE;
                        out_q       <= final_d;
                        zero_q      <= (a_q == b_q);
                        lt_q        <= ($signed(a_q) < $signed(b_q));
                        dbz_q       <= dbz_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out         = out_q;
    assign bus.Zero        = zero_q;
    assign bus.LessThan    = lt_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the datapath ALU: same single-cycle operation set, generalised to WIDTH bits.
- Adds iterative unsigned multiply, divide and remainder units with a valid/ready handshake.
- Sits in the execute stage; the controller stalls on in_ready=0.
- Result and compare flags are registered; no combinational path from operands to outputs.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept (high only in IDLE)
- A  input  WIDTH  operand A (signed view where op requires)
- B  input  WIDTH  operand B
- control  input  4  operation select
- out_valid  output  1  one-cycle pulse: result/flags valid
- out  output  WIDTH  result, held until next accepted op completes
- Zero  output  1  registered (A==B) of accepted operands
- LessThan  output  1  registered signed (A<B) of accepted operands
- div_by_zero  output  1  registered; set with out_valid for DIVU/REMU with B==0

Behaviour:
- Accept: in_valid && in_ready at a rising edge; A, B, control latched; Zero/LessThan computed from latched values.
- Ops:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sltu (1/0), 0101 slt signed (1/0), 0110 xor: single-cycle.
  - 1000 MUL: low WIDTH bits of unsigned product, shift-add.
  - 1001 DIVU: quotient, restoring division.
  - 1010 REMU: remainder, restoring division.
  - All other codes behave as add.
- Arithmetic: add/sub wrap modulo 2^WIDTH, no carry/overflow output.
- FSM:
  - IDLE (in_ready=1): on accept of a single-cycle op -> DONE; on accept of a multi-cycle op -> RUN with counter=0.
  - RUN (in_ready=0): one iteration per cycle; counter increments; at counter==WIDTH-1 -> DONE.
  - DONE (in_ready=0, out_valid=1): one cycle, out/flags updated, -> IDLE.
- Latency, measured from the accept edge:
  - Single-cycle ops: out_valid high in the following cycle.
  - Multi-cycle ops: out_valid high WIDTH+1 cycles later.
- Throughput: at most one op per 2 cycles (single) or WIDTH+2 cycles (multi).
- in_valid while in_ready=0: ignored, not queued.
- Divide by zero, skipping iteration: DIVU -> all ones, REMU -> A, div_by_zero=1. Latency is unchanged (still WIDTH+1).
- out, Zero, LessThan, div_by_zero hold their last values between ops. They change only in DONE.
- Reset (any state, including mid-RUN): state=IDLE, counter=0, out=0, Zero=0, LessThan=0, div_by_zero=0, out_valid=0, in_ready=1 in the cycle after rst is sampled. A partially computed op is discarded with no out_valid.
- rst has priority over an accept in the same cycle.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_DIV_EN.
- With the macro defined, two extra codes are decoded:
  - 1011 DIV: signed quotient, truncated toward zero.
  - 1100 REM: signed remainder; sign follows A.
  - Both are implemented as magnitude division with sign fix-up applied in DONE; latency is the same as DIVU.
  - Divide by zero: DIV -> all ones, REM -> A, div_by_zero=1.
  - Overflow (A = most-negative, B = -1): DIV -> A, REM -> 0, div_by_zero=0.
- Without the macro: 1011 and 1100 behave as add; no sign-fix logic is synthesised.

Test Plan:
- WIDTH=32, A=7, B=5, control=0001 -> out=2 one cycle after accept, Zero=0, LessThan=0, out_valid single pulse.
- A=-1 (0xFFFFFFFF), B=1, control=0100 -> out=0; control=0101 -> out=1, LessThan=1.
- A=123456, B=789, control=1000 -> out=97406784 exactly 33 cycles after accept; in_ready=0 throughout; in_valid pulses during RUN ignored.
- A=100, B=7: DIVU -> 14, REMU -> 2. A=100, B=0: DIVU -> 0xFFFFFFFF, REMU -> 100, div_by_zero=1, both after 33 cycles.
- Assert rst at RUN cycle 10 of a MUL -> next cycle state IDLE, in_ready=1, out=0, no out_valid; a new add 3+4 then returns 7.
- With ALU_SEQ_SIGNED_DIV_EN: DIV -7/2 -> -3, REM -> -1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Without the macro: control=1011, A=3, B=4 -> out=7.
